// File: rtl/cursor_tracker.sv
// Etch-A-Sketch cursor: turns X/Y encoder count changes into a clamped cursor and pixel writes, plus a full-screen erase.
// Optional macro CURSOR_WRAP_EN: cursor position wraps modulo the screen size instead of saturating.
module cursor_tracker #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4:0]     x_enc,
    input  logic [4:0]     y_enc,
    input  logic           clr_req,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic           wr_ink,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           busy
);

    localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 4;

    typedef enum logic [1:0] {PRIME, IDLE, DRAW, CLEAR} state_t;

    state_t         state_r, state_s;
    logic [4:0]     x_prev_r, x_prev_s, y_prev_r, y_prev_s;
    logic [4:0]     dx_s, dy_s;
    logic           clr_pend_r, clr_pend_s;
    logic [X_W-1:0] cur_x_r, cur_x_s, wr_x_r, wr_x_s, new_x_s;
    logic [Y_W-1:0] cur_y_r, cur_y_s, wr_y_r, wr_y_s, new_y_s;
    logic           wr_valid_r, wr_valid_s, wr_ink_r, wr_ink_s, busy_r, busy_s;

    // New coordinate from old one plus signed 5-bit delta scaled by STEP; sum is always in range of CW signed bits.
    function automatic logic [CW-1:0] advance(input logic [CW-1:0] pos, input logic [4:0] d, input int res);
        logic signed [CW-1:0] sum;
        logic signed [CW-1:0] lim;
        sum = $signed(pos) + $signed({{(CW-5){d[4]}}, d}) * $signed(CW'(STEP));
        lim = $signed(CW'(res));
`ifdef CURSOR_WRAP_EN
        if (sum[CW-1]) begin
            advance = sum + lim;
        end else if (sum >= lim) begin
            advance = sum - lim;
        end else begin
            advance = sum;
        end
`else
        if (sum[CW-1]) begin
            advance = {CW{1'b0}};
        end else if (sum >= lim) begin
            advance = lim - $signed(CW'(1));
        end else begin
            advance = sum;
        end
`endif
    endfunction

    assign dx_s    = x_enc - x_prev_r;
    assign dy_s    = y_enc - y_prev_r;
    assign new_x_s = X_W'(advance(CW'(cur_x_r), dx_s, H_RES));
    assign new_y_s = Y_W'(advance(CW'(cur_y_r), dy_s, V_RES));

    // Next-state and next-output logic for the tracker FSM.
    always_comb begin
        state_s    = state_r;
        x_prev_s   = x_prev_r;
        y_prev_s   = y_prev_r;
        clr_pend_s = clr_pend_r;
        cur_x_s    = cur_x_r;
        cur_y_s    = cur_y_r;
        wr_valid_s = wr_valid_r;
        wr_x_s     = wr_x_r;
        wr_y_s     = wr_y_r;
        wr_ink_s   = wr_ink_r;
        case (state_r)
            PRIME: begin
                x_prev_s = x_enc;
                y_prev_s = y_enc;
                state_s  = IDLE;
            end
            IDLE: begin
                // Clear wins over a move; prev is held so the move is picked up afterwards.
                if (clr_pend_r || clr_req) begin
                    state_s    = CLEAR;
                    wr_valid_s = 1'b1;
                    wr_x_s     = {X_W{1'b0}};
                    wr_y_s     = {Y_W{1'b0}};
                    wr_ink_s   = 1'b0;
                end else if ((dx_s != 5'd0) || (dy_s != 5'd0)) begin
                    x_prev_s   = x_enc;
                    y_prev_s   = y_enc;
                    cur_x_s    = new_x_s;
                    cur_y_s    = new_y_s;
                    state_s    = DRAW;
                    wr_valid_s = 1'b1;
                    wr_x_s     = new_x_s;
                    wr_y_s     = new_y_s;
                    wr_ink_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAW: begin
                if (clr_req) begin
                    clr_pend_s = 1'b1;
                end else begin
                    clr_pend_s = clr_pend_r;
                end
                if (wr_ready) begin
                    wr_valid_s = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = DRAW;
                end
            end
            CLEAR: begin
                if (wr_ready) begin
                    if (wr_x_r == X_W'(H_RES - 1)) begin
                        wr_x_s = {X_W{1'b0}};
                        if (wr_y_r == Y_W'(V_RES - 1)) begin
                            wr_valid_s = 1'b0;
                            clr_pend_s = 1'b0;
                            state_s    = IDLE;
                        end else begin
                            wr_y_s = wr_y_r + Y_W'(1);
                        end
                    end else begin
                        wr_x_s = wr_x_r + X_W'(1);
                    end
                end else begin
                    state_s = CLEAR;
                end
            end
            default: begin
                state_s    = PRIME;
                wr_valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s == DRAW) || (state_s == CLEAR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PRIME;
            x_prev_r   <= 5'd0;
            y_prev_r   <= 5'd0;
            clr_pend_r <= 1'b0;
            cur_x_r    <= X_W'(H_RES / 2);
            cur_y_r    <= Y_W'(V_RES / 2);
            wr_valid_r <= 1'b0;
            wr_x_r     <= {X_W{1'b0}};
            wr_y_r     <= {Y_W{1'b0}};
            wr_ink_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            x_prev_r   <= x_prev_s;
            y_prev_r   <= y_prev_s;
            clr_pend_r <= clr_pend_s;
            cur_x_r    <= cur_x_s;
            cur_y_r    <= cur_y_s;
            wr_valid_r <= wr_valid_s;
            wr_x_r     <= wr_x_s;
            wr_y_r     <= wr_y_s;
            wr_ink_r   <= wr_ink_s;
            busy_r     <= busy_s;
        end
    end

    assign wr_valid = wr_valid_r;
    assign wr_x     = wr_x_r;
    assign wr_y     = wr_y_r;
    assign wr_ink   = wr_ink_r;
    assign cur_x    = cur_x_r;
    assign cur_y    = cur_y_r;
    assign busy     = busy_r;

endmodule
